xillybus_wrapper_mac_pipe: RTL and testbench

//  Pipelined, parametrised multiply-accumulate for the coprocess datapath; successor to the single-cycle DSP48 multiplier.
//  Per-operand widths and signedness are configurable, with NUM_STAGE pipelined multiply stages and a valid/ready handshake.

---
 rtl/xillybus_wrapper_mac_pipe.sv | 165 ++++++++++++++++
 tb/tb_xillybus_wrapper_mac_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/xillybus_wrapper_mac_pipe.sv
// xillybus_wrapper_mac_pipe: pipelined multiply-accumulate with a valid/ready handshake.
// The operands, the accumulate/last flags and a valid bit travel together through NUM_STAGE
// multiply stages. One further accumulator stage either emits a plain product or sums the
// products of an accumulation run.
// Optional feature: define MAC_SATURATE_EN to clamp accumulator overflow and report it on
// acc_sat. Without it, sums wrap at ACC_WIDTH and acc_sat stays 0.
module xillybus_wrapper_mac_pipe #(
    parameter logic [31:0] ID          = 32'd1,
    parameter int          NUM_STAGE   = 2,
    parameter int          din0_WIDTH  = 15,
    parameter int          din1_WIDTH  = 15,
    parameter int          din0_SIGNED = 0,
    parameter int          din1_SIGNED = 1,
    parameter int          ACC_WIDTH   = 48
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  in_acc,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ACC_WIDTH-1:0]  dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  acc_sat
);

    localparam int PW = din0_WIDTH + din1_WIDTH + 2;
    localparam int LS = NUM_STAGE - 1;

    if (NUM_STAGE < 1 || NUM_STAGE > 4) begin : g_cfg_err
        $error("xillybus_wrapper_mac_pipe %0d: NUM_STAGE must be 1..4", ID);
    end

    logic                          en_s;
    logic signed [din0_WIDTH:0]    a_ext_s;
    logic signed [din1_WIDTH:0]    b_ext_s;
    logic signed [PW-1:0]          mul_s;

    logic signed [PW-1:0]          prod_q [NUM_STAGE];
    logic                          vld_q  [NUM_STAGE];
    logic                          accf_q [NUM_STAGE];
    logic                          last_q [NUM_STAGE];

    logic signed [ACC_WIDTH-1:0]   prod_ext_s;
    logic signed [ACC_WIDTH-1:0]   sum_s;
    logic                          clamp_s;

    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0]   dout_q, dout_d;
    logic                          out_valid_q, out_valid_d;
    logic                          acc_sat_q, acc_sat_d;
    logic                          sticky_q, sticky_d;

    // The whole pipeline advances only when the output register is free or being drained.
    assign en_s      = !out_valid_q || out_ready;
    assign in_ready  = en_s;
    assign dout      = dout_q;
    assign out_valid = out_valid_q;
    assign acc_sat   = acc_sat_q;

    // Extend each operand by one bit (sign or zero) and form the signed product.
    always_comb begin
        a_ext_s = {((din0_SIGNED != 0) ? din0[din0_WIDTH-1] : 1'b0), din0};
        b_ext_s = {((din1_SIGNED != 0) ? din1[din1_WIDTH-1] : 1'b0), din1};
        mul_s   = PW'(a_ext_s) * PW'(b_ext_s);
    end

    // Multiply pipeline: the product is captured in stage 0 and carried with its beat flags.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int s = 0; s < NUM_STAGE; s++) begin
                prod_q[s] <= '0;
                vld_q[s]  <= 1'b0;
                accf_q[s] <= 1'b0;
                last_q[s] <= 1'b0;
            end
        end else if (en_s) begin
            prod_q[0] <= mul_s;
            vld_q[0]  <= in_valid;
            accf_q[0] <= in_acc;
            last_q[0] <= in_last;
            for (int s = 1; s < NUM_STAGE; s++) begin
                prod_q[s] <= prod_q[s-1];
                vld_q[s]  <= vld_q[s-1];
                accf_q[s] <= accf_q[s-1];
                last_q[s] <= last_q[s-1];
            end
        end
    end

`ifdef MAC_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    logic signed [ACC_WIDTH:0] sum_wide_s;

    // Add one bit of headroom and clamp to the signed range when the top two bits disagree.
    always_comb begin
        prod_ext_s = ACC_WIDTH'(prod_q[LS]);
        sum_wide_s = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(prod_ext_s);
        if (sum_wide_s[ACC_WIDTH] != sum_wide_s[ACC_WIDTH-1]) begin
            clamp_s = 1'b1;
            sum_s   = sum_wide_s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            clamp_s = 1'b0;
            sum_s   = sum_wide_s[ACC_WIDTH-1:0];
        end
    end
`else
    // Plain two's-complement sum that wraps at ACC_WIDTH; never reports a clamp.
    always_comb begin
        prod_ext_s = ACC_WIDTH'(prod_q[LS]);
        sum_s      = acc_q + prod_ext_s;
        clamp_s    = 1'b0;
    end
`endif

    // Accumulator stage next state: plain product, partial sum, or closing sum.
    always_comb begin
        acc_d       = acc_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        acc_sat_d   = acc_sat_q;
        sticky_d    = sticky_q;
        if (vld_q[LS]) begin
            if (!accf_q[LS]) begin
                dout_d      = prod_ext_s;
                out_valid_d = 1'b1;
                acc_sat_d   = 1'b0;
            end else if (!last_q[LS]) begin
                acc_d       = sum_s;
                sticky_d    = sticky_q | clamp_s;
                out_valid_d = 1'b0;
            end else begin
                dout_d      = sum_s;
                out_valid_d = 1'b1;
                acc_d       = '0;
                acc_sat_d   = sticky_q | clamp_s;
                sticky_d    = 1'b0;
            end
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // Accumulator and output registers, frozen while the downstream stalls.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q       <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            acc_sat_q   <= 1'b0;
            sticky_q    <= 1'b0;
        end else if (en_s) begin
            acc_q       <= acc_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            acc_sat_q   <= acc_sat_d;
            sticky_q    <= sticky_d;
        end
    end

endmodule

// File: tb/tb_xillybus_wrapper_mac_pipe.sv
// Bench for xillybus_wrapper_mac_pipe: directed beats with hand-computed results pushed into
// a scoreboard queue; a monitor pops and compares whenever an output is handed over.
// Two instances share stimulus: the default configuration, and a 32-bit accumulator with
// unsigned operands used for the overflow case. Only the selected one is scored.
module tb_xillybus_wrapper_mac_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] din0 = 15'd0;
    logic [14:0] din1 = 15'd0;
    logic        in_acc = 1'b0;
    logic        in_last = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready0, out_valid0, acc_sat0;
    logic [47:0] dout0;
    logic        in_ready1, out_valid1, acc_sat1;
    logic [31:0] dout1;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          stall_lo = 0;
    int          stall_hi = 0;
    int          sel = 0;
    longint      exp_d[$];
    bit          exp_s[$];

    xillybus_wrapper_mac_pipe u_dut0 (
        .ap_clk(clk), .ap_rst_n(rst_n), .din0(din0), .din1(din1),
        .in_acc(in_acc), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready0),
        .dout(dout0), .out_valid(out_valid0), .out_ready(out_ready), .acc_sat(acc_sat0)
    );

    xillybus_wrapper_mac_pipe #(.din1_SIGNED(0), .ACC_WIDTH(32)) u_dut1 (
        .ap_clk(clk), .ap_rst_n(rst_n), .din0(din0), .din1(din1),
        .in_acc(in_acc), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready1),
        .dout(dout1), .out_valid(out_valid1), .out_ready(out_ready), .acc_sat(acc_sat1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream back-pressure window.
    always @(negedge clk) out_ready = !(cyc >= stall_lo && cyc < stall_hi);

    // Scoreboard monitor: one pop per handed-over result.
    always @(negedge clk) begin
        longint got_d;
        bit     got_s;
        bit     fire;
        #2;
        fire = 1'b0;
        got_d = 0;
        got_s = 1'b0;
        if (rst_n && sel == 0 && out_valid0 && out_ready) begin
            fire = 1'b1;
            got_d = longint'($signed(dout0));
            got_s = acc_sat0;
        end
        if (rst_n && sel == 1 && out_valid1 && out_ready) begin
            fire = 1'b1;
            got_d = longint'($signed(dout1));
            got_s = acc_sat1;
        end
        if (fire) begin
            n_tests++;
            if (exp_d.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_unexpected: got dout=%0d sat=%0b, required no output", got_d, got_s);
            end else begin
                longint e_d;
                bit     e_s;
                e_d = exp_d.pop_front();
                e_s = exp_s.pop_front();
                if (got_d !== e_d || got_s !== e_s) begin
                    n_fail++;
                    $display("FAIL scoreboard_result: got dout=%0d sat=%0b, required dout=%0d sat=%0b",
                             got_d, got_s, e_d, e_s);
                end
            end
        end
    end

    task automatic push(input longint d, input bit s);
        exp_d.push_back(d);
        exp_s.push_back(s);
    endtask

    task automatic check(input string name, input longint got, input longint req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // Present one beat and hold it until accepted; acc_cyc is the cycle of acceptance.
    task automatic send(input logic [14:0] a, input logic [14:0] b, input logic ac,
                        input logic la, output int acc_cyc);
        int t;
        t = 0;
        @(negedge clk);
        #1;
        din0 = a; din1 = b; in_acc = ac; in_last = la; in_valid = 1'b1;
        forever begin
            if (cyc >= stall_lo && cyc < stall_hi) check("in_ready_stalled", longint'(in_ready0), 0);
            if (in_ready0 || t >= 100) break;
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 100) check("send_timeout", 0, 1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_d.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", longint'(exp_d.size()), 0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int c;
        #200000;
        $display("FAIL watchdog: got simulation time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset_out_valid0", longint'(out_valid0), 0);
        check("reset_dout0", longint'(dout0), 0);
        check("reset_acc_sat0", longint'(acc_sat0), 0);
        check("reset_out_valid1", longint'(out_valid1), 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("in_ready_after_reset", longint'(in_ready0), 1);

        // 1: plain product 32767 * -1, latency three cycles
        push(-64'sd32767, 1'b0);
        send(15'd32767, 15'h7FFF, 1'b0, 1'b0, c);
        for (int k = 0; k < 10 && cyc < c + 2; k++) @(negedge clk);
        #1;
        check("latency_not_yet", longint'(out_valid0), 0);
        @(negedge clk);
        #1;
        check("latency_valid", longint'(out_valid0), 1);
        drain();

        // 2: four accumulate beats 100*3 -> 1200
        push(64'sd1200, 1'b0);
        for (int i = 0; i < 4; i++) send(15'd100, 15'd3, 1'b1, (i == 3), c);
        drain();

        // 3: stream of 16 plain beats with a back-pressure window
        @(negedge clk);
        stall_lo = cyc + 4;
        stall_hi = cyc + 9;
        for (int i = 0; i < 16; i++) begin
            push(longint'(2 * i), 1'b0);
            send(15'(i), 15'd2, 1'b0, 1'b0, c);
        end
        drain();
        stall_lo = 0;
        stall_hi = 0;

        // 4: reset during an accumulation, then a fresh 5*5 + 5*5
        send(15'd9, 15'd9, 1'b1, 1'b0, c);
        send(15'd9, 15'd9, 1'b1, 1'b0, c);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", longint'(out_valid0), 0);
        repeat (2) @(negedge clk);
        #1;
        check("midreset_dout", longint'(dout0), 0);
        rst_n = 1'b1;
        push(64'sd50, 1'b0);
        send(15'd5, 15'd5, 1'b1, 1'b0, c);
        send(15'd5, 15'd5, 1'b1, 1'b1, c);
        drain();

        // 5: 32-bit accumulator, three beats 32767*32767
        sel = 1;
`ifdef MAC_SATURATE_EN
        push(64'sd2147483647, 1'b1);
`else
        push(-64'sd1073938429, 1'b0);
`endif
        for (int i = 0; i < 3; i++) send(15'd32767, 15'd32767, 1'b1, (i == 2), c);
        drain();
        sel = 0;

        // 6: plain beat inside an accumulation
        push(64'sd49, 1'b0);
        push(64'sd200, 1'b0);
        send(15'd10, 15'd10, 1'b1, 1'b0, c);
        send(15'd7, 15'd7, 1'b0, 1'b0, c);
        send(15'd10, 15'd10, 1'b1, 1'b1, c);
        drain();

        check("scoreboard_empty", longint'(exp_d.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
